// File: rtl/systolic_tile_sequencer.sv
// Output-stationary GEMM tile sequencer: operand/output SRAM strobes, skewed FIFO enables, PE compute/flush control.
// Strobes start one cycle after START; STALL freezes all state for that cycle. TILE_SEQ_PERF_CNT_EN adds perf counters.
module systolic_tile_sequencer #(
    parameter int NUM_ROWS      = 32,
    parameter int NUM_ROWS_LOG2 = 5,
    parameter int NUM_COLS      = 32,
    parameter int NUM_COLS_LOG2 = 5,
    parameter int MAX_M_LOG2    = 9,
    parameter int MAX_K_LOG2    = 9,
    parameter int MAX_N_LOG2    = 9,
    parameter int OPND1_AWIDTH  = 10,
    parameter int OPND2_AWIDTH  = 10,
    parameter int OUT_AWIDTH    = 10
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic                              STALL,
    input  logic [MAX_M_LOG2-1:0]             M_SIZE_in,
    input  logic [MAX_K_LOG2-1:0]             K_SIZE_in,
    input  logic [MAX_N_LOG2-1:0]             N_SIZE_in,
    input  logic                              ORDER_in,
    output logic [OPND1_AWIDTH-1:0]           OPND1_SRAM_ADDR_out,
    output logic                              OPND1_SRAM_REN_out,
    output logic [OPND2_AWIDTH-1:0]           OPND2_SRAM_ADDR_out,
    output logic                              OPND2_SRAM_REN_out,
    output logic [OUT_AWIDTH-1:0]             OUT_SRAM_ADDR_out,
    output logic                              OUT_SRAM_WEN_out,
    output logic [NUM_ROWS-1:0]               OPND1_FIFO_PUSHEs_out,
    output logic [NUM_ROWS-1:0]               OPND1_FIFO_POPEs_out,
    output logic [NUM_COLS-1:0]               OPND2_FIFO_PUSHEs_out,
    output logic [NUM_COLS-1:0]               OPND2_FIFO_POPEs_out,
    output logic                              IS_COMPUTING_out,
    output logic                              IS_FLUSHING_out,
    output logic                              BUSY_out,
    output logic                              IS_FINISHED_out,
    output logic [MAX_M_LOG2-NUM_ROWS_LOG2:0] TILE_ROW_ID_out,
    output logic [MAX_N_LOG2-NUM_COLS_LOG2:0] TILE_COL_ID_out,
    output logic [NUM_ROWS_LOG2:0]            ACTV_ROWS_out,
    output logic [NUM_COLS_LOG2:0]            ACTV_COLS_out
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                       PERF_CYCLES_out,
    output logic [31:0]                       PERF_STALLS_out
`endif
);
    localparam int TRW = MAX_M_LOG2 - NUM_ROWS_LOG2 + 1;
    localparam int TCW = MAX_N_LOG2 - NUM_COLS_LOG2 + 1;
    localparam int ARW = NUM_ROWS_LOG2 + 1;
    localparam int ACW = NUM_COLS_LOG2 + 1;
    localparam int CW  = MAX_K_LOG2 + 2;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [MAX_M_LOG2-1:0]   r_m;
    logic [MAX_K_LOG2-1:0]   r_k;
    logic [MAX_N_LOG2-1:0]   r_n;
    logic                    r_order;
    logic [TRW-1:0]          r_tr_total, r_tile_row, w_nxt_tr;
    logic [TCW-1:0]          r_tc_total, r_tile_col, w_nxt_tc;
    logic [ARW-1:0]          r_actv_rows, w_nxt_ar, w_init_ar, r_fc;
    logic [ACW-1:0]          r_actv_cols, w_nxt_ac, w_init_ac;
    logic [CW-1:0]           r_cc, w_k_ext, w_e;
    logic [OPND1_AWIDTH-1:0] r_opnd1_addr;
    logic [OPND2_AWIDTH-1:0] r_opnd2_addr;
    logic [OUT_AWIDTH-1:0]   r_out_addr, w_out_base;
    logic                    r_ren_q, w_ren, w_wen, w_pop_en, w_busy;
    logic                    w_zero, w_cc_last, w_fc_last, w_last_tile;
    logic [31:0]             w_rem_rows, w_rem_cols;

    assign w_zero      = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);
    assign w_busy      = (r_state == S_COMPUTE) || (r_state == S_FLUSH);
    assign w_k_ext     = CW'(r_k);
    assign w_e         = w_k_ext + CW'(r_actv_rows) + CW'(r_actv_cols) - CW'(1);
    assign w_cc_last   = (r_cc == w_e);
    assign w_fc_last   = (r_fc == r_actv_rows - ARW'(1));
    assign w_last_tile = (r_tile_row == r_tr_total - TRW'(1)) && (r_tile_col == r_tc_total - TCW'(1));
    assign w_pop_en    = (r_state == S_COMPUTE) && !STALL;

    assign w_init_ar  = (32'(M_SIZE_in) >= 32'(NUM_ROWS)) ? ARW'(NUM_ROWS) : ARW'(M_SIZE_in);
    assign w_init_ac  = (32'(N_SIZE_in) >= 32'(NUM_COLS)) ? ACW'(NUM_COLS) : ACW'(N_SIZE_in);
    assign w_rem_rows = 32'(r_m) - 32'(w_nxt_tr) * 32'(NUM_ROWS);
    assign w_rem_cols = 32'(r_n) - 32'(w_nxt_tc) * 32'(NUM_COLS);
    assign w_nxt_ar   = (w_rem_rows >= 32'(NUM_ROWS)) ? ARW'(NUM_ROWS) : ARW'(w_rem_rows);
    assign w_nxt_ac   = (w_rem_cols >= 32'(NUM_COLS)) ? ACW'(NUM_COLS) : ACW'(w_rem_cols);
    // First output row of the tile: (tr*NUM_ROWS)*TC + tc, wrapped to the SRAM width.
    assign w_out_base = OUT_AWIDTH'(32'(r_tile_row) * 32'(NUM_ROWS) * 32'(r_tc_total) + 32'(r_tile_col));

    always_comb begin
        w_nxt_tr = r_tile_row;
        w_nxt_tc = r_tile_col;
        if (!r_order) begin
            if (r_tile_col == r_tc_total - TCW'(1)) begin
                w_nxt_tc = '0;
                w_nxt_tr = r_tile_row + TRW'(1);
            end else begin
                w_nxt_tc = r_tile_col + TCW'(1);
            end
        end else begin
            if (r_tile_row == r_tr_total - TRW'(1)) begin
                w_nxt_tr = '0;
                w_nxt_tc = r_tile_col + TCW'(1);
            end else begin
                w_nxt_tr = r_tile_row + TRW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        w_wen       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) w_state_nxt = w_zero ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                w_ren = (r_cc < w_k_ext) && !STALL;
                if (!STALL && w_cc_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_wen = !STALL;
                if (!STALL && w_fc_last) w_state_nxt = w_last_tile ? S_DONE : S_COMPUTE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m <= '0; r_k <= '0; r_n <= '0; r_order <= 1'b0;
            r_tr_total <= '0; r_tc_total <= '0; r_tile_row <= '0; r_tile_col <= '0;
            r_actv_rows <= '0; r_actv_cols <= '0; r_cc <= '0; r_fc <= '0;
            r_opnd1_addr <= '0; r_opnd2_addr <= '0; r_out_addr <= '0; r_ren_q <= 1'b0;
        end else begin
            r_ren_q <= w_ren;
            case (r_state)
                S_IDLE: begin
                    if (START && !w_zero) begin
                        r_m          <= M_SIZE_in;
                        r_k          <= K_SIZE_in;
                        r_n          <= N_SIZE_in;
                        r_order      <= ORDER_in;
                        r_tr_total   <= TRW'((32'(M_SIZE_in) + 32'(NUM_ROWS - 1)) >> NUM_ROWS_LOG2);
                        r_tc_total   <= TCW'((32'(N_SIZE_in) + 32'(NUM_COLS - 1)) >> NUM_COLS_LOG2);
                        r_tile_row   <= '0;
                        r_tile_col   <= '0;
                        r_actv_rows  <= w_init_ar;
                        r_actv_cols  <= w_init_ac;
                        r_cc         <= '0;
                        r_fc         <= '0;
                        r_opnd1_addr <= '0;
                        r_opnd2_addr <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (w_ren) begin
                        r_opnd1_addr <= r_opnd1_addr + OPND1_AWIDTH'(r_tr_total);
                        r_opnd2_addr <= r_opnd2_addr + OPND2_AWIDTH'(r_tc_total);
                    end
                    if (!STALL) begin
                        if (w_cc_last) begin
                            r_fc       <= '0;
                            r_out_addr <= w_out_base;
                        end else begin
                            r_cc <= r_cc + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!STALL) begin
                        r_out_addr <= r_out_addr + OUT_AWIDTH'(r_tc_total);
                        r_fc       <= r_fc + ARW'(1);
                        if (w_fc_last && !w_last_tile) begin
                            r_tile_row   <= w_nxt_tr;
                            r_tile_col   <= w_nxt_tc;
                            r_actv_rows  <= w_nxt_ar;
                            r_actv_cols  <= w_nxt_ac;
                            r_cc         <= '0;
                            r_opnd1_addr <= OPND1_AWIDTH'(w_nxt_tr);
                            r_opnd2_addr <= OPND2_AWIDTH'(w_nxt_tc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pushes track last cycle's read (one-cycle SRAM latency) and are never stall-gated.
    always_comb begin
        OPND1_FIFO_PUSHEs_out = '0;
        OPND1_FIFO_POPEs_out  = '0;
        OPND2_FIFO_PUSHEs_out = '0;
        OPND2_FIFO_POPEs_out  = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            OPND1_FIFO_PUSHEs_out[i] = r_ren_q && (ARW'(i) < r_actv_rows);
            OPND1_FIFO_POPEs_out[i]  = w_pop_en && (ARW'(i) < r_actv_rows) &&
                                       (r_cc >= CW'(i + 1)) && (r_cc <= w_k_ext + CW'(i));
        end
        for (int j = 0; j < NUM_COLS; j++) begin
            OPND2_FIFO_PUSHEs_out[j] = r_ren_q && (ACW'(j) < r_actv_cols);
            OPND2_FIFO_POPEs_out[j]  = w_pop_en && (ACW'(j) < r_actv_cols) &&
                                       (r_cc >= CW'(j + 1)) && (r_cc <= w_k_ext + CW'(j));
        end
    end

    assign OPND1_SRAM_ADDR_out = r_opnd1_addr;
    assign OPND1_SRAM_REN_out  = w_ren;
    assign OPND2_SRAM_ADDR_out = r_opnd2_addr;
    assign OPND2_SRAM_REN_out  = w_ren;
    assign OUT_SRAM_ADDR_out   = r_out_addr;
    assign OUT_SRAM_WEN_out    = w_wen;
    assign IS_COMPUTING_out    = (r_state == S_COMPUTE);
    assign IS_FLUSHING_out     = (r_state == S_FLUSH);
    assign BUSY_out            = w_busy;
    assign IS_FINISHED_out     = (r_state == S_DONE);
    assign TILE_ROW_ID_out     = r_tile_row;
    assign TILE_COL_ID_out     = r_tile_col;
    assign ACTV_ROWS_out       = r_actv_rows;
    assign ACTV_COLS_out       = r_actv_cols;

`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles, r_perf_stalls;

    always_ff @(posedge CLK) begin
        if (RST || (r_state == S_IDLE && START)) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_busy) begin
            if (r_perf_cycles != '1)          r_perf_cycles <= r_perf_cycles + 32'd1;
            if (STALL && r_perf_stalls != '1) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign PERF_CYCLES_out = r_perf_cycles;
    assign PERF_STALLS_out = r_perf_stalls;
`endif
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: per-cycle comparison against a tile-level reference trace.
module tb_systolic_tile_sequencer;
    localparam int NR = 32;
    localparam int NC = 32;

    logic        CLK = 1'b0;
    logic        RST, START, STALL, ORDER_in;
    logic [8:0]  M_SIZE_in, K_SIZE_in, N_SIZE_in;
    logic [9:0]  OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out, OUT_SRAM_ADDR_out;
    logic        OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, OUT_SRAM_WEN_out;
    logic [31:0] OPND1_FIFO_PUSHEs_out, OPND1_FIFO_POPEs_out, OPND2_FIFO_PUSHEs_out, OPND2_FIFO_POPEs_out;
    logic        IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, IS_FINISHED_out;
    logic [4:0]  TILE_ROW_ID_out, TILE_COL_ID_out;
    logic [5:0]  ACTV_ROWS_out, ACTV_COLS_out;
`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] PERF_CYCLES_out, PERF_STALLS_out;
`endif

    systolic_tile_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .STALL(STALL),
        .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in), .ORDER_in(ORDER_in),
        .OPND1_SRAM_ADDR_out(OPND1_SRAM_ADDR_out), .OPND1_SRAM_REN_out(OPND1_SRAM_REN_out),
        .OPND2_SRAM_ADDR_out(OPND2_SRAM_ADDR_out), .OPND2_SRAM_REN_out(OPND2_SRAM_REN_out),
        .OUT_SRAM_ADDR_out(OUT_SRAM_ADDR_out), .OUT_SRAM_WEN_out(OUT_SRAM_WEN_out),
        .OPND1_FIFO_PUSHEs_out(OPND1_FIFO_PUSHEs_out), .OPND1_FIFO_POPEs_out(OPND1_FIFO_POPEs_out),
        .OPND2_FIFO_PUSHEs_out(OPND2_FIFO_PUSHEs_out), .OPND2_FIFO_POPEs_out(OPND2_FIFO_POPEs_out),
        .IS_COMPUTING_out(IS_COMPUTING_out), .IS_FLUSHING_out(IS_FLUSHING_out),
        .BUSY_out(BUSY_out), .IS_FINISHED_out(IS_FINISHED_out),
        .TILE_ROW_ID_out(TILE_ROW_ID_out), .TILE_COL_ID_out(TILE_COL_ID_out),
        .ACTV_ROWS_out(ACTV_ROWS_out), .ACTV_COLS_out(ACTV_COLS_out)
`ifdef TILE_SEQ_PERF_CNT_EN
        , .PERF_CYCLES_out(PERF_CYCLES_out), .PERF_STALLS_out(PERF_STALLS_out)
`endif
    );

    always #5 CLK = ~CLK;

    wire [186:0] all_out = {OPND1_SRAM_ADDR_out, OPND1_SRAM_REN_out, OPND2_SRAM_ADDR_out, OPND2_SRAM_REN_out,
                            OUT_SRAM_ADDR_out, OUT_SRAM_WEN_out, OPND1_FIFO_PUSHEs_out, OPND1_FIFO_POPEs_out,
                            OPND2_FIFO_PUSHEs_out, OPND2_FIFO_POPEs_out, IS_COMPUTING_out, IS_FLUSHING_out,
                            BUSY_out, IS_FINISHED_out, TILE_ROW_ID_out, TILE_COL_ID_out, ACTV_ROWS_out, ACTV_COLS_out};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          ren;
        int          a1, a2;
        bit          wen;
        int          oa;
        logic [31:0] p1, p2;
        int          tr, tc, ar, ac;
        bit          comp;
    } step_t;
    step_t trace[$];

    function automatic logic [31:0] lanes(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n && i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Expected busy-cycle trace of a whole job, listed tile by tile in traversal order.
    function automatic void build(input int m, input int k, input int n, input bit order);
        int    trn, tcn, tr, tc, ar, ac, e;
        step_t s;
        trace.delete();
        if (m == 0 || k == 0 || n == 0) return;
        trn = (m + NR - 1) / NR;
        tcn = (n + NC - 1) / NC;
        for (int o = 0; o < trn * tcn; o++) begin
            tr = order ? o % trn : o / tcn;
            tc = order ? o / trn : o % tcn;
            ar = (m - tr * NR) < NR ? (m - tr * NR) : NR;
            ac = (n - tc * NC) < NC ? (n - tc * NC) : NC;
            e  = k + ar + ac - 1;
            for (int cc = 0; cc <= e; cc++) begin
                s.ren = (cc < k); s.a1 = (cc * trn + tr) % 1024; s.a2 = (cc * tcn + tc) % 1024;
                s.wen = 1'b0; s.oa = 0; s.p1 = '0; s.p2 = '0;
                for (int i = 0; i < ar; i++) if (cc >= i + 1 && cc <= k + i) s.p1[i] = 1'b1;
                for (int j = 0; j < ac; j++) if (cc >= j + 1 && cc <= k + j) s.p2[j] = 1'b1;
                s.tr = tr; s.tc = tc; s.ar = ar; s.ac = ac; s.comp = 1'b1;
                trace.push_back(s);
            end
            for (int fc = 0; fc < ar; fc++) begin
                s.ren = 1'b0; s.a1 = 0; s.a2 = 0; s.wen = 1'b1;
                s.oa = ((tr * NR + fc) * tcn + tc) % 1024; s.p1 = '0; s.p2 = '0;
                s.tr = tr; s.tc = tc; s.ar = ar; s.ac = ac; s.comp = 1'b0;
                trace.push_back(s);
            end
        end
    endfunction

    task automatic run_op(input int m, input int k, input int n, input bit order,
                          input int stall_at, input int stall_len, input bit rnd_stall, input bit rnd_start);
        int          idx, stalls, ear, eac;
        bit          prev_ren, stl;
        logic [31:0] ep1, ep2;
        step_t       s;
        build(m, k, n, order);
        @(posedge CLK); #1;
        START = 1'b1; M_SIZE_in = 9'(m); K_SIZE_in = 9'(k); N_SIZE_in = 9'(n); ORDER_in = order;
        STALL = 1'($urandom_range(0, 1));
        @(negedge CLK);
        n_checks++;
        if ({BUSY_out, IS_FINISHED_out, OPND1_SRAM_REN_out, OUT_SRAM_WEN_out} !== 4'b0) begin
            n_fail++; $display("FAIL idle_before_start got=%b want=0000",
                               {BUSY_out, IS_FINISHED_out, OPND1_SRAM_REN_out, OUT_SRAM_WEN_out});
        end
        idx = 0; stalls = 0; prev_ren = 1'b0;
        while (idx < trace.size()) begin
            @(posedge CLK); #1;
            START = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            M_SIZE_in = 9'($urandom); K_SIZE_in = 9'($urandom); N_SIZE_in = 9'($urandom);
            ORDER_in = 1'($urandom);
            stl   = rnd_stall ? (stalls < 60 && $urandom_range(0, 5) == 0) : (idx == stall_at && stalls < stall_len);
            STALL = stl;
            ear = trace[idx].ar; eac = trace[idx].ac;
            @(negedge CLK);
            ep1 = prev_ren ? lanes(ear) : '0;
            ep2 = prev_ren ? lanes(eac) : '0;
            n_checks++;
            if (OPND1_FIFO_PUSHEs_out !== ep1) begin
                n_fail++; $display("FAIL push1 idx=%0d got=%h want=%h", idx, OPND1_FIFO_PUSHEs_out, ep1);
            end
            n_checks++;
            if (OPND2_FIFO_PUSHEs_out !== ep2) begin
                n_fail++; $display("FAIL push2 idx=%0d got=%h want=%h", idx, OPND2_FIFO_PUSHEs_out, ep2);
            end
            if (stl) begin
                n_checks++;
                if ({OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, OUT_SRAM_WEN_out, |OPND1_FIFO_POPEs_out,
                     |OPND2_FIFO_POPEs_out, BUSY_out, IS_FINISHED_out} !== 7'b0000010) begin
                    n_fail++; $display("FAIL stall_gating idx=%0d got=%b want=0000010", idx,
                        {OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, OUT_SRAM_WEN_out, |OPND1_FIFO_POPEs_out,
                         |OPND2_FIFO_POPEs_out, BUSY_out, IS_FINISHED_out});
                end
                stalls++;
                prev_ren = 1'b0;
            end else begin
                s = trace[idx];
                n_checks++;
                if ({OPND1_SRAM_REN_out, OPND2_SRAM_REN_out} !== {s.ren, s.ren}) begin
                    n_fail++; $display("FAIL ren idx=%0d got=%b%b want=%b", idx, OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, s.ren);
                end
                if (s.ren) begin
                    n_checks++;
                    if (OPND1_SRAM_ADDR_out !== 10'(s.a1) || OPND2_SRAM_ADDR_out !== 10'(s.a2)) begin
                        n_fail++; $display("FAIL rd_addr idx=%0d got=%0d/%0d want=%0d/%0d", idx,
                                           OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out, s.a1, s.a2);
                    end
                end
                n_checks++;
                if (OUT_SRAM_WEN_out !== s.wen) begin
                    n_fail++; $display("FAIL wen idx=%0d got=%b want=%b", idx, OUT_SRAM_WEN_out, s.wen);
                end
                if (s.wen) begin
                    n_checks++;
                    if (OUT_SRAM_ADDR_out !== 10'(s.oa)) begin
                        n_fail++; $display("FAIL wr_addr idx=%0d got=%0d want=%0d", idx, OUT_SRAM_ADDR_out, s.oa);
                    end
                end
                n_checks++;
                if (OPND1_FIFO_POPEs_out !== s.p1 || OPND2_FIFO_POPEs_out !== s.p2) begin
                    n_fail++; $display("FAIL pope idx=%0d got=%h/%h want=%h/%h", idx,
                                       OPND1_FIFO_POPEs_out, OPND2_FIFO_POPEs_out, s.p1, s.p2);
                end
                n_checks++;
                if ({IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, IS_FINISHED_out} !== {s.comp, !s.comp, 2'b10}) begin
                    n_fail++; $display("FAIL status idx=%0d got=%b want=%b", idx,
                        {IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, IS_FINISHED_out}, {s.comp, !s.comp, 2'b10});
                end
                n_checks++;
                if (TILE_ROW_ID_out !== 5'(s.tr) || TILE_COL_ID_out !== 5'(s.tc) ||
                    ACTV_ROWS_out !== 6'(s.ar) || ACTV_COLS_out !== 6'(s.ac)) begin
                    n_fail++; $display("FAIL tile idx=%0d got=(%0d,%0d) %0d/%0d want=(%0d,%0d) %0d/%0d", idx,
                        TILE_ROW_ID_out, TILE_COL_ID_out, ACTV_ROWS_out, ACTV_COLS_out, s.tr, s.tc, s.ar, s.ac);
                end
                prev_ren = s.ren;
                idx++;
            end
        end
        @(posedge CLK); #1;
        STALL = 1'($urandom_range(0, 1));
        START = 1'($urandom_range(0, 1));
        M_SIZE_in = 9'($urandom); K_SIZE_in = 9'($urandom); N_SIZE_in = 9'($urandom);
        @(negedge CLK);
        n_checks++;
        if ({IS_FINISHED_out, BUSY_out, OPND1_SRAM_REN_out, OUT_SRAM_WEN_out, |OPND1_FIFO_PUSHEs_out} !== 5'b10000) begin
            n_fail++; $display("FAIL finish_pulse m=%0d k=%0d n=%0d got=%b want=10000", m, k, n,
                {IS_FINISHED_out, BUSY_out, OPND1_SRAM_REN_out, OUT_SRAM_WEN_out, |OPND1_FIFO_PUSHEs_out});
        end
`ifdef TILE_SEQ_PERF_CNT_EN
        n_checks++;
        if (PERF_CYCLES_out !== 32'(trace.size() + stalls) || PERF_STALLS_out !== 32'(stalls)) begin
            n_fail++; $display("FAIL perf got=%0d/%0d want=%0d/%0d", PERF_CYCLES_out, PERF_STALLS_out,
                               trace.size() + stalls, stalls);
        end
`endif
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1 STALL = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_held got=%h want=0", all_out);
        end
        @(posedge CLK); #1;
        RST = 1'b0; STALL = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_release got=%h want=0", all_out);
        end
    endtask

    task automatic test_full_tile;      run_op(32, 32, 32, 0, -1, 0, 0, 0); endtask
    task automatic test_partial_rowmaj; run_op(40, 8, 48, 0, -1, 0, 0, 0);  endtask
    task automatic test_partial_colmaj; run_op(40, 8, 48, 1, -1, 0, 0, 0);  endtask
    task automatic test_stall;          run_op(32, 32, 32, 0, 5, 3, 0, 0);  endtask
    task automatic test_addr_wrap;
        run_op(1, 70, 511, 0, -1, 0, 0, 0);
        run_op(511, 1, 100, 1, -1, 0, 0, 0);
    endtask
    task automatic test_zero_size;
        run_op(20, 0, 20, 0, -1, 0, 0, 0);
        run_op(0, 5, 7, 1, -1, 0, 0, 0);
        run_op(9, 3, 0, 0, -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_flush;
        @(posedge CLK); #1;
        START = 1'b1; M_SIZE_in = 9'd32; K_SIZE_in = 9'd32; N_SIZE_in = 9'd32; ORDER_in = 1'b0; STALL = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        @(negedge CLK);
        n_checks++;
        if ({IS_FLUSHING_out, OUT_SRAM_WEN_out, OUT_SRAM_ADDR_out} !== {2'b11, 10'd4}) begin
            n_fail++; $display("FAIL mid_flush got=%b%b addr=%0d want=11 addr=4", IS_FLUSHING_out, OUT_SRAM_WEN_out, OUT_SRAM_ADDR_out);
        end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL rst_abort got=%h want=0", all_out);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_checks++;
            if ({IS_FINISHED_out, BUSY_out} !== 2'b00) begin
                n_fail++; $display("FAIL rst_no_finish cyc=%0d got=%b want=00", c, {IS_FINISHED_out, BUSY_out});
            end
        end
        run_op(32, 4, 40, 0, -1, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 6; r++)
            run_op($urandom_range(1, 100), $urandom_range(1, 24), $urandom_range(1, 100),
                   1'($urandom_range(0, 1)), -1, 0, 1, 1);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; STALL = 1'b0; ORDER_in = 1'b0;
        M_SIZE_in = '0; K_SIZE_in = '0; N_SIZE_in = '0;
        test_reset;
        test_full_tile;
        test_partial_rowmaj;
        test_partial_colmaj;
        test_stall;
        test_zero_size;
        test_addr_wrap;
        test_reset_mid_flush;
        test_back_to_back;
        @(posedge CLK); #1;
        START = 1'b0; STALL = 1'b0;
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
